// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-sequencer state encoding.
package regfile_pkg;
  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rd_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cidx = sum[IDX_W-1:0];
      if (!found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end
endmodule

// File: rtl/regfile_rd_arbiter.sv
// Round-robin sharing of the register file's single async read port, with
// same-cycle writeback bypass and a snapshot valid/ready response.
module regfile_rd_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int REG_ID_W = regfile_pkg::REG_ID_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ID_W-1:0]  req_reg_id,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_rd_en,
  output logic [REG_ID_W-1:0]          rf_rd_id,
  input  logic [DATA_W-1:0]            rf_rd_data,
  input  logic                         wr_en,
  input  logic [REG_ID_W-1:0]          wr_id,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_W-1:0]            rsp_data
);
  import regfile_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rd_state_t             state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, owner_q, owner_d;
  logic [REG_ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // id_q only changes on the edge into READ, so it doubles as the held read index.
  assign rf_rd_id = id_q;
  assign rsp_data = data_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    id_d      = id_q;
    data_d    = data_q;
    req_ready = '0;
    rf_rd_en  = 1'b0;
    rsp_valid = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          req_ready = pick_gnt;
          if (|req_valid) begin
            owner_d = pick_idx;
            id_d    = req_reg_id[pick_idx*REG_ID_W +: REG_ID_W];
            ptr_d   = (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          rf_rd_en = 1'b1;
          data_d   = (wr_en && wr_id == id_q) ? wr_data : rf_rd_data;
          state_d  = RESP;
        end
        RESP: begin
          rsp_valid[owner_q] = 1'b1;
          if (rsp_ready[owner_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Directed bench: stimulus pushes expected responses, a monitor pops them on each accepted response.
module tb_regfile_rd_arbiter;
  logic        clk, rst;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [11:0] req_reg_id;
  logic        rf_rd_en, wr_en;
  logic [3:0]  rf_rd_id, wr_id;
  logic [15:0] rf_rd_data, wr_data, rsp_data;
  logic [15:0] rf_mem [16];

  typedef struct packed {
    logic [2:0]  oh;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  regfile_rd_arbiter #(.NUM_REQ(3), .REG_ID_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_reg_id(req_reg_id), .req_ready(req_ready),
    .rf_rd_en(rf_rd_en), .rf_rd_id(rf_rd_id), .rf_rd_data(rf_rd_data),
    .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  assign rf_rd_data = rf_mem[rf_rd_id];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input int i, input logic [3:0] id);
    req_reg_id[i*4 +: 4] = id;
  endtask

  task automatic push(input logic [2:0] oh, input logic [15:0] data);
    sb.push_back({oh, data});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rf_rd_en"},  rf_rd_en,  0);
    chk({tag, "_rf_rd_id"},  rf_rd_id,  0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data,  0);
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && |(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got valid 0x%0h data 0x%0h, want none", rsp_valid, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_owner", rsp_valid, e.oh);
          chk("sb_rsp_data",  rsp_data,  e.data);
        end
      end
    end
  end

  initial begin
    logic [2:0]  oh;
    logic [15:0] rr_exp [3];
    rr_exp = '{16'h1001, 16'h2002, 16'h3003};
    for (int r = 0; r < 16; r++) rf_mem[r] = 16'h0;
    rf_mem[1] = 16'h1001; rf_mem[2] = 16'h2002; rf_mem[3] = 16'h3003;
    rf_mem[4] = 16'h4444; rf_mem[5] = 16'hBEEF; rf_mem[7] = 16'h1111;
    rst = 1'b1; req_valid = 3'b111; req_reg_id = '0; rsp_ready = '0;
    wr_en = 1'b0; wr_id = '0; wr_data = '0;

    // Reset state, with requests asserted to confirm outputs stay quiet.
    step(); step();
    chk_all_zero("reset");
    req_valid = '0; rst = 1'b0;

    // 1: single request from requester 1 for R5.
    step();
    set_id(1, 4'd5); req_valid = 3'b010; rsp_ready = 3'b111;
    push(3'b010, 16'hBEEF);
    #1 chk("t1_grant", req_ready, 3'b010);
    step(); req_valid = '0;
    #1 chk("t1_rd_en", rf_rd_en, 1); chk("t1_rd_id", rf_rd_id, 5); chk("t1_ready_read", req_ready, 0);
    step();
    #1 chk("t1_rsp_valid", rsp_valid, 3'b010); chk("t1_rsp_data", rsp_data, 16'hBEEF);
    step();
    #1 chk("t1_idle_valid", rsp_valid, 0); chk("t1_idle_data_hold", rsp_data, 16'hBEEF);
    chk("t1_idle_rd_en", rf_rd_en, 0);

    // 2: all requesters valid from a fresh pointer -> 0,1,2,0,1,2.
    rst = 1'b1; step(); rst = 1'b0;
    set_id(0, 4'd1); set_id(1, 4'd2); set_id(2, 4'd3);
    req_valid = 3'b111; rsp_ready = 3'b111;
    for (int g = 0; g < 6; g++) begin
      oh = 3'b001 << (g % 3);
      #1 chk("t2_rr_grant", req_ready, oh);
      push(oh, rr_exp[g % 3]);
      step();
      #1 chk("t2_rr_rd_id", rf_rd_id, (g % 3) + 1);
      step(); step();
    end
    req_valid = '0;

    // 3: bypass in READ, snapshot in RESP.
    set_id(0, 4'd7); req_valid = 3'b001; rsp_ready = '0;
    #1 chk("t3_grant", req_ready, 3'b001);
    push(3'b001, 16'h2222);
    step(); req_valid = '0;
    wr_en = 1'b1; wr_id = 4'd7; wr_data = 16'h2222;
    #1 chk("t3_rd_en", rf_rd_en, 1); chk("t3_rd_id", rf_rd_id, 7);
    step(); rf_mem[7] = 16'h2222; wr_data = 16'h3333;
    #1 chk("t3_bypass_data", rsp_data, 16'h2222); chk("t3_rsp_valid", rsp_valid, 3'b001);
    step(); rf_mem[7] = 16'h3333; wr_en = 1'b0;
    #1 chk("t3_snapshot", rsp_data, 16'h2222);
    rsp_ready = 3'b001;
    step(); rsp_ready = '0;

    // 4/6: backpressure with others waiting, wrong-bit accept ignored.
    set_id(2, 4'd4); req_valid = 3'b100;
    #1 chk("t4_grant", req_ready, 3'b100);
    push(3'b100, 16'h4444);
    step(); set_id(0, 4'd1); set_id(1, 4'd2); req_valid = 3'b011;
    step();
    for (int c = 0; c < 4; c++) begin
      rsp_ready = (c == 1) ? 3'b011 : 3'b000;
      #1 chk("t4_hold_valid", rsp_valid, 3'b100); chk("t4_hold_data", rsp_data, 16'h4444);
      chk("t4_hold_ready", req_ready, 0); chk("t4_hold_rd_en", rf_rd_en, 0);
      step();
    end
    rsp_ready = 3'b100;
    #1 chk("t6_still_resp", rsp_valid, 3'b100);
    step(); rsp_ready = 3'b111;
    #1 chk("t4_next_grant", req_ready, 3'b001);
    push(3'b001, 16'h1001);
    step(); req_valid = 3'b010;
    step(); step();
    #1 chk("t4_after_grant", req_ready, 3'b010);
    push(3'b010, 16'h2002);
    step(); req_valid = '0;
    step(); step();

    // 5: reset in READ, then reset in RESP.
    rsp_ready = '0; set_id(0, 4'd1); set_id(2, 4'd3); req_valid = 3'b001;
    #1 chk("t5_grant_a", req_ready, 3'b001);
    step(); rst = 1'b1;
    step();
    chk_all_zero("t5_rst_read");
    rst = 1'b0; req_valid = 3'b101;
    #1 chk("t5_ptr_reset_a", req_ready, 3'b001);
    step(); req_valid = 3'b100;
    step();
    #1 chk("t5_resp_valid", rsp_valid, 3'b001); chk("t5_resp_data", rsp_data, 16'h1001);
    rst = 1'b1;
    step();
    chk_all_zero("t5_rst_resp");
    rst = 1'b0; req_valid = 3'b101;
    #1 chk("t5_ptr_reset_b", req_ready, 3'b001); chk("t5_no_stale", rsp_valid, 0);
    push(3'b001, 16'h1001); rsp_ready = 3'b111;
    step(); req_valid = '0;
    step(); step(); step();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
